// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helpers
package aes_pkg;

    localparam logic [7:0] INV_AFFINE_C = 8'h05;
    localparam logic [7:0] SBOX_C       = 8'h63;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } isb_state_t;

    // Multiply modulo the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic aes_byte_t gf_mul(aes_byte_t a, aes_byte_t b);
        aes_byte_t p;
        aes_byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic aes_byte_t inv_affine(aes_byte_t b);
        aes_byte_t r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ INV_AFFINE_C[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// rtl/inv_sub_bytes_seq_if.sv - state in/out handshake bundle for inv_sub_bytes_seq
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;
    logic       busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/inv_gf_256.sv
// rtl/inv_gf_256.sv - combinational GF(2^8) multiplicative inverse, 0 maps to 0
module inv_gf_256
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t y
);

    // a^254 == a^-1 for nonzero a, and 0^254 == 0 falls out naturally.
    aes_byte_t a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;

    always_comb begin
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        y    = gf_mul(a252, a2);
    end

endmodule

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box: field inverse of InvAffine(a)
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t y
);

    aes_byte_t aff;

    assign aff = inv_affine(a);

    inv_gf_256 u_inv (
        .a (aff),
        .y (y)
    );

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - multi-cycle InvSubBytes over a 128-bit state, LANES bytes per beat
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    inv_sub_bytes_seq_if.slave  bus
);

    localparam int BEATS = 16 / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    isb_state_t      state_q;
    logic [BW-1:0]   beat_q;
    aes_state_t      work_q;

    aes_byte_t       sb_in  [LANES];
    aes_byte_t       sb_out [LANES];
    logic [6:0]      lane_pos [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_pos[l] = {4'(int'(beat_q) * LANES + l), 3'b000};
        assign sb_in[l]    = work_q[lane_pos[l] +: 8];

        inv_sbox u_sbox (
            .a (sb_in[l]),
            .y (sb_out[l])
        );
    end

    // In DONE the slot frees as the result leaves, so a new state can land on the same edge.
    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.out_data  = work_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            work_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_data;
                        beat_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        work_q[lane_pos[l] +: 8] <= sb_out[l];
                    end
                    if (beat_q == BW'(BEATS - 1)) begin
                        beat_q  <= '0;
                        state_q <= DONE;
                    end else begin
                        beat_q  <= beat_q + BW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            work_q  <= bus.in_data;
                            beat_q  <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
